// File: rtl/trng_com_pkg.sv
// Shared definitions for the TRNG serial link: 8N1 frame levels, receiver FSM states
// and the default bit period the transmitter and receiver agree on.
package trng_com_pkg;
    localparam int   DATA_BITS        = 8;
    localparam logic START_LVL        = 1'b0;
    localparam logic STOP_LVL         = 1'b1;
    localparam logic IDLE_LVL         = 1'b1;
    localparam int   CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;
endpackage

// File: rtl/trng_com_rx_fifo.sv
// Show-ahead byte FIFO for the link receiver; head is the oldest entry and reads 0 when empty.
module trng_com_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        push,
    input  logic [7:0]  wr_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end
endmodule

// File: rtl/trng_com_rx.sv
// 8N1 receiver for the TRNG link: synchronizer, mid-bit sampling FSM, receive FIFO
// and RTS throttling of the far-end transmitter.
module trng_com_rx
    import trng_com_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int RTS_MARGIN   = 1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_serial_data,
    output logic       o_serial_rts_n,
    output logic [7:0] o_dat,
    output logic       o_valid,
    input  logic       i_read,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic [3:0] o_frame_cnt
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] HALF    = TW'(CLKS_PER_BIT/2 - 1);
    localparam logic [TW-1:0] FULL    = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   RTS_THR = (AW+1)'(FIFO_DEPTH - RTS_MARGIN - 1);

    logic          rx_meta, rx_s;
    rx_state_e     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          push, err_n, ovr_n, tick, pop, empty, full;
    logic [AW:0]   count;

    assign tick = (timer == '0);
    assign pop  = i_read & ~empty;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_serial_data;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        push      = 1'b0;
        err_n     = 1'b0;
        ovr_n     = 1'b0;
        case (state)
            IDLE: if (rx_s == START_LVL) begin
                state_n = START;
                timer_n = HALF;
            end
            START: begin
                if (!tick) timer_n = timer - TW'(1);
                else if (rx_s == START_LVL) begin
                    state_n   = DATA;
                    timer_n   = FULL;
                    bit_cnt_n = '0;
                end else state_n = IDLE;
            end
            DATA: begin
                if (!tick) timer_n = timer - TW'(1);
                else begin
                    shreg_n   = {rx_s, shreg[7:1]};
                    timer_n   = FULL;
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (!tick) timer_n = timer - TW'(1);
                else if (rx_s == STOP_LVL) begin
                    state_n = IDLE;
                    if (!full || pop) push = 1'b1;
                    else ovr_n = 1'b1;
                end else begin
                    state_n = BREAK;
                    err_n   = 1'b1;
                end
            end
            BREAK: if (rx_s == IDLE_LVL) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state          <= IDLE;
            timer          <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
            o_frame_cnt    <= '0;
            o_serial_rts_n <= 1'b1;
        end else begin
            state          <= state_n;
            timer          <= timer_n;
            bit_cnt        <= bit_cnt_n;
            shreg          <= shreg_n;
            o_frame_err    <= err_n;
            o_overrun      <= ovr_n;
            if (push) o_frame_cnt <= o_frame_cnt + 4'd1;
            o_serial_rts_n <= (count > RTS_THR);
        end
    end

    trng_com_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .push      (push),
        .wr_data   (shreg),
        .pop       (pop),
        .head      (o_dat),
        .empty     (empty),
        .full      (full),
        .count     (count)
    );

    assign o_valid = ~empty;
endmodule

// File: tb/tb_trng_com_rx.sv
// Bench for trng_com_rx: serial frame driver, scoreboard on the read side, vector table
// plus directed sequences for timing, overrun, break, glitch and mid-frame reset.
module tb_trng_com_rx;
    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser = 1'b1;
    logic       rts_n;
    logic [7:0] dat;
    logic       valid;
    logic       rd = 1'b0;
    logic       ferr, ovr;
    logic [3:0] fcnt;

    int         tests = 0, failed = 0;
    int         err_cnt = 0, ovr_cnt = 0;
    logic [3:0] exp_fcnt = 4'd0;
    logic [7:0] q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_push;
        logic       exp_err;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    trng_com_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .RTS_MARGIN(1)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_serial_data  (ser),
        .o_serial_rts_n (rts_n),
        .o_dat          (dat),
        .o_valid        (valid),
        .i_read         (rd),
        .o_frame_err    (ferr),
        .o_overrun      (ovr),
        .o_frame_cnt    (fcnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pop of the head is compared against the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) err_cnt++;
            if (ovr)  ovr_cnt++;
            if (valid && rd) begin
                if (q.size() == 0) chk("unexpected_byte", {24'd0, dat}, 32'hFFFF_FFFF);
                else chk("rx_byte", {24'd0, dat}, {24'd0, q.pop_front()});
            end
        end
    end

    // Called right after a negedge; the line drops immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        ser = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser = b[i];
            repeat (C) @(negedge clk);
        end
        ser = stop;
        repeat (C) @(negedge clk);
        ser = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (!valid && q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_valid_low", {31'd0, valid}, 0);
    endtask

    initial begin
        int e0, o0;
        tbl[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h55, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'hAA, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{8'h81, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'hC3, 1'b0, 1'b0, 1'b1};

        // Reset state
        idle(3);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_dat", {24'd0, dat}, 0);
        chk("rst_rts_n", {31'd0, rts_n}, 1);
        chk("rst_fcnt", {28'd0, fcnt}, 0);
        chk("rst_pulses", {30'd0, ferr, ovr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rts_after_release", {31'd0, rts_n}, 0);

        // Loopback-style stream: 20 back-to-back bytes, reader always ready
        rd = 1'b1;
        e0 = err_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 20; i++) begin
            q.push_back(8'(i));
            exp_fcnt = exp_fcnt + 4'd1;
            send_frame(8'(i), 1'b1);
        end
        drain();
        chk("stream_fcnt", {28'd0, fcnt}, 32'd4);
        chk("stream_no_pulses", err_cnt - e0 + ovr_cnt - o0, 0);

        // Exact latency of o_valid for one frame
        rd = 1'b0;
        idle(2 * C);
        q.push_back(8'hA5);
        exp_fcnt = exp_fcnt + 4'd1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2 + C/2 + 9*C) @(negedge clk);
                chk("valid_before_stop_edge", {31'd0, valid}, 0);
                @(negedge clk);
                chk("valid_after_stop_edge", {31'd0, valid}, 1);
                chk("head_a5", {24'd0, dat}, 32'hA5);
            end
        join
        rd = 1'b1;
        drain();

        // Vector table
        for (int i = 0; i < 6; i++) begin
            e0 = err_cnt;
            if (tbl[i].exp_push) begin
                q.push_back(tbl[i].d);
                exp_fcnt = exp_fcnt + 4'd1;
            end
            send_frame(tbl[i].d, tbl[i].stop);
            idle(2 * C);
            chk($sformatf("vec%0d_err", i), err_cnt - e0, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_fcnt", i), {28'd0, fcnt}, {28'd0, exp_fcnt});
        end
        drain();

        // Fill with reader stalled: RTS after 3rd push, overrun on 5th frame
        rd = 1'b0;
        o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) begin
                q.push_back(8'(i));
                exp_fcnt = exp_fcnt + 4'd1;
            end
            send_frame(8'(i), 1'b1);
            if (i == 2) chk("rts_after_2", {31'd0, rts_n}, 0);
            if (i == 3) chk("rts_after_3", {31'd0, rts_n}, 1);
            if (i == 4) chk("ovr_after_4", ovr_cnt - o0, 0);
        end
        idle(2);
        chk("ovr_after_5", ovr_cnt - o0, 1);
        chk("fill_fcnt", {28'd0, fcnt}, {28'd0, exp_fcnt});
        rd = 1'b1;
        drain();
        chk("rts_after_drain", {31'd0, rts_n}, 0);

        // Bad stop bit, long break, then a good frame
        e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        ser = 1'b0;
        idle(30 * C);
        ser = 1'b1;
        idle(2 * C);
        chk("break_fcnt", {28'd0, fcnt}, {28'd0, exp_fcnt});
        q.push_back(8'h77);
        exp_fcnt = exp_fcnt + 4'd1;
        send_frame(8'h77, 1'b1);
        idle(4);
        drain();
        chk("break_err_once", err_cnt - e0, 1);
        chk("break_then_fcnt", {28'd0, fcnt}, {28'd0, exp_fcnt});

        // Short low glitch on idle line
        e0 = err_cnt; o0 = ovr_cnt;
        ser = 1'b0;
        idle(3);
        ser = 1'b1;
        idle(3 * C);
        chk("glitch_pulses", err_cnt - e0 + ovr_cnt - o0, 0);
        chk("glitch_fcnt", {28'd0, fcnt}, {28'd0, exp_fcnt});
        chk("glitch_valid", {31'd0, valid}, 0);
        q.push_back(8'h5A);
        exp_fcnt = exp_fcnt + 4'd1;
        send_frame(8'h5A, 1'b1);
        drain();

        // Reset in the middle of a data phase with two bytes buffered
        rd = 1'b0;
        q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        ser = 1'b0;
        idle(4 * C);
        rst_n = 1'b0;
        ser = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, valid}, 0);
        chk("midrst_fcnt", {28'd0, fcnt}, 0);
        chk("midrst_rts_n", {31'd0, rts_n}, 1);
        q.delete();
        exp_fcnt = 4'd0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rts_release", {31'd0, rts_n}, 0);
        rd = 1'b1;
        idle(2 * C);
        q.push_back(8'h99);
        exp_fcnt = exp_fcnt + 4'd1;
        send_frame(8'h99, 1'b1);
        drain();
        chk("midrst_after_fcnt", {28'd0, fcnt}, {28'd0, exp_fcnt});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
